// File: rtl/out_uart_tx_pkg.sv
// Shared types and constants for the output-register UART mirror.
// Serializer states, bit-timing helper and the ASCII table used by the optional sequencer.
package out_uart_tx_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } ser_state_e;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam logic [7:0] HEX_TAB [16] = '{
        8'h30, 8'h31, 8'h32, 8'h33,
        8'h34, 8'h35, 8'h36, 8'h37,
        8'h38, 8'h39, 8'h41, 8'h42,
        8'h43, 8'h44, 8'h45, 8'h46
    };

    function automatic int clks_per_bit(
        input int clk_freq,
        input int baud
    );
        return clk_freq / baud;
    endfunction

    function automatic logic [7:0] hex_char(
        input logic [3:0] nib
    );
        return HEX_TAB[nib];
    endfunction

endpackage

// File: rtl/out_uart_tx_if.sv
// CPU-side view of the output register load: bus value, OI strobe, bus clock level.
// The CPU/control side is the master; the UART mirror only listens.
interface out_uart_tx_if;

    logic [7:0] bus;
    logic       OI;
    logic       bus_clk;

    modport master (
        output bus,
        output OI,
        output bus_clk
    );

    modport slave (
        input bus,
        input OI,
        input bus_clk
    );

endinterface

// File: rtl/out_uart_tx_frame.sv
// 8N1 frame serializer: one byte per accepted valid, LSB first, registered line.
// ready is high in IDLE and in the final STOP cycle so frames can run back-to-back.
module uart_tx_frame
    import out_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    ser_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          last;

    assign last  = (cnt_q == CNT_MAX);
    assign ready = (state_q == S_IDLE) ||
                   ((state_q == S_STOP) && last);
    assign tx    = tx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = last ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (valid) begin
                    shift_d = data;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (last) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (last) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (last) begin
                    if (valid) begin
                        shift_d = data;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Line level follows the next state so tx is a clean flop output.
        unique case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/out_uart_tx.sv
// Mirrors every output-register load onto a UART line for the host.
// Define OUT_UART_TX_ASCII_EN to send each value as "HH\r\n" instead of a raw byte.
module out_uart_tx
    import out_uart_tx_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 1000000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    out_uart_tx_if.slave  cpu,
    output logic          tx,
    output logic          busy,
    output logic          overflow
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] cnt_q, cnt_d;
    logic        bclk_q;
    logic        push, push_ok, pop;
    logic        full, empty;
    logic        fvalid, fready, accept;
    logic [7:0]  fdata;
    logic        act_q, act_d;
    logic        busy_q, busy_d;
    logic        ovf_q;
    logic        seq_busy_d;

    assign push    = cpu.bus_clk & ~bclk_q & cpu.OI;
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == DEPTH_L);
    assign push_ok = push & (~full | pop);
    assign accept  = fvalid & fready;

`ifdef OUT_UART_TX_ASCII_EN
    logic [1:0] chr_q, chr_d;
    logic [3:0] lo_q, lo_d;

    // Entry leaves the FIFO on its first character; low nibble is kept for the second.
    always_comb begin
        chr_d  = chr_q;
        lo_d   = lo_q;
        pop    = 1'b0;
        fvalid = (chr_q != 2'd0) | ~empty;
        unique case (chr_q)
            2'd0:    fdata = hex_char(mem_q[rd_q][7:4]);
            2'd1:    fdata = hex_char(lo_q);
            2'd2:    fdata = ASCII_CR;
            default: fdata = ASCII_LF;
        endcase
        if (accept) begin
            chr_d = chr_q + 2'd1;
            if (chr_q == 2'd0) begin
                pop  = 1'b1;
                lo_d = mem_q[rd_q][3:0];
            end
        end
        seq_busy_d = (chr_d != 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chr_q <= '0;
            lo_q  <= '0;
        end else begin
            chr_q <= chr_d;
            lo_q  <= lo_d;
        end
    end
`else
    assign fvalid     = ~empty;
    assign fdata      = mem_q[rd_q];
    assign pop        = accept;
    assign seq_busy_d = 1'b0;
`endif

    always_comb begin
        cnt_d = cnt_q;
        if (push_ok && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push_ok && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
        // Mirrors the serializer leaving IDLE without peeking at its state.
        act_d = accept ? 1'b1 : (fready ? 1'b0 : act_q);
        busy_d = act_d | (cnt_d != '0) | seq_busy_d;
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q] <= cpu.bus;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_q <= 1'b0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            act_q  <= 1'b0;
            busy_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            bclk_q <= cpu.bus_clk;
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop)     rd_q <= rd_q + 1'b1;
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            busy_q <= busy_d;
            ovf_q  <= ovf_q | (push & full & ~pop);
        end
    end

    uart_tx_frame #(
        .CLKS_PER_BIT (CPB)
    ) u_frame (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (fdata),
        .valid (fvalid),
        .ready (fready),
        .tx    (tx)
    );

    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_out_uart_tx.sv
// Scoreboard bench for out_uart_tx: a timing model predicts every frame and its start cycle,
// a line monitor decodes tx and compares against the queue.
module tb_out_uart_tx;

    localparam int CLK_FREQ = 100000000;
    localparam int BAUD     = 1000000;
    localparam int DEPTH    = 4;
    localparam int C        = CLK_FREQ / BAUD;
`ifdef OUT_UART_TX_ASCII_EN
    localparam int CHARS = 4;
    localparam int NRAND = 5;
`else
    localparam int CHARS = 1;
    localparam int NRAND = 25;
`endif
    localparam int FRAME = 10 * C * CHARS;
    localparam int DRAIN = (DEPTH + 2) * FRAME + 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx, busy, overflow;

    out_uart_tx_if bif ();

    out_uart_tx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu      (bif),
        .tx       (tx),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] ch;
        longint     fall;
    } exp_t;

    exp_t   sb[$];
    longint pops[$];
    longint last_pop;
    bit     ov_m;
    int     nvec = 0;
    int     nerr = 0;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @%0d: got %0h want %0h",
                     nm, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] d);
        return (d < 4'd10) ? 8'd48 + {4'd0, d}
                           : 8'd55 + {4'd0, d};
    endfunction

    function automatic void model_reset();
        sb.delete();
        pops.delete();
        last_pop = -64'sd1000000;
        ov_m = 1'b0;
    endfunction

    // Capture at posedge n: an entry occupies the queue until its pop
    // cycle; pops are FRAME apart and never earlier than n+1.
    function automatic void model_capture(input longint n,
                                          input logic [7:0] b);
        longint p;
        exp_t e;
        while (pops.size() > 0 && pops[0] <= n)
            void'(pops.pop_front());
        if (pops.size() >= DEPTH) begin
            ov_m = 1'b1;
            return;
        end
        p = (n + 1 > last_pop + FRAME) ? n + 1 : last_pop + FRAME;
        last_pop = p;
        pops.push_back(p);
        if (CHARS == 1) begin
            e.ch = b; e.fall = p; sb.push_back(e);
        end else begin
            e.ch = hexc(b[7:4]); e.fall = p;         sb.push_back(e);
            e.ch = hexc(b[3:0]); e.fall = p + 10*C;  sb.push_back(e);
            e.ch = 8'h0D;        e.fall = p + 20*C;  sb.push_back(e);
            e.ch = 8'h0A;        e.fall = p + 30*C;  sb.push_back(e);
        end
    endfunction

    bit         mon_act = 1'b0;
    bit         mon_bad, mon_skip;
    int         mon_j;
    logic [9:0] mon_frm;
    logic [7:0] mon_rx;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            mon_act = 1'b0;
        end else if (mon_act) begin
            if (tx !== mon_frm[mon_j / C]) mon_bad = 1'b1;
            if (mon_j >= C && mon_j < 9*C && (mon_j % C) == C/2)
                mon_rx[(mon_j / C) - 1] = tx;
            mon_j++;
            if (mon_j == 10*C) begin
                mon_act = 1'b0;
                if (!mon_skip) begin
                    nvec++;
                    if (mon_bad) begin
                        nerr++;
                        $display("FAIL frame: got %0h want %0h",
                                 mon_rx, mon_frm[8:1]);
                    end
                end
            end
        end else if (tx === 1'b0) begin
            mon_act = 1'b1;
            mon_j   = 1;
            mon_bad = 1'b0;
            mon_rx  = '0;
            if (sb.size() == 0) begin
                mon_skip = 1'b1;
                mon_frm  = 10'h201;
                nvec++;
                nerr++;
                $display("FAIL unexpected_frame @%0d: got start want none",
                         cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                mon_skip = 1'b0;
                mon_frm  = {1'b1, e.ch, 1'b0};
                chk("start_cycle", 64'(cyc), 64'(e.fall));
            end
        end
    end

    task automatic capture(input logic [7:0] b, input bit oi,
                           input int hold);
        bif.bus     = b;
        bif.OI      = oi;
        bif.bus_clk = 1'b1;
        if (oi) model_capture(longint'(cyc) + 1, b);
        @(negedge clk);
        chk("overflow", 64'(overflow), 64'(ov_m));
        bif.OI  = 1'b1;
        bif.bus = 8'($urandom);
        repeat (hold) @(negedge clk);
        bif.bus_clk = 1'b0;
        bif.OI      = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || mon_act || busy) && t < DRAIN) begin
            @(negedge clk);
            t++;
        end
        chk("drain", {62'd0, busy, sb.size() != 0}, 64'd0);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint p;
        bit bad_tx, bad_busy;
        bif.bus     = '0;
        bif.OI      = 1'b0;
        bif.bus_clk = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        chk("rst_tx", 64'(tx), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single byte: start bit two cycles after the drive, busy drop
        p = longint'(cyc) + 2;
        capture(8'h5A, 1'b1, 1);
        while (cyc < p + FRAME - 1) @(negedge clk);
        chk("busy_hi", 64'(busy), 64'd1);
        @(negedge clk);
        chk("busy_fall", 64'(busy), 64'd0);
        drain();

        // OI low on the edge: nothing queued
        capture(8'hFF, 1'b0, 30);
        bad_tx = 0; bad_busy = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx = 1;
            if (busy !== 1'b0) bad_busy = 1;
        end
        chk("oi0_tx", 64'(bad_tx), 64'd0);
        chk("oi0_busy", 64'(bad_busy), 64'd0);

        // burst to fill the FIFO, sixth capture dropped
        for (int i = 1; i <= 6; i++) capture(8'(i), 1'b1, 0);
        drain();

        // reset in the middle of DATA
        p = longint'(cyc) + 2;
        capture(8'hC3, 1'b1, 1);
        while (cyc < p + 5*C) @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_tx", 64'(tx), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ovf", 64'(overflow), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad_tx = 0; bad_busy = 0;
        repeat (2000) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx = 1;
            if (busy !== 1'b0) bad_busy = 1;
        end
        chk("postrst_tx", 64'(bad_tx), 64'd0);
        chk("postrst_busy", 64'(bad_busy), 64'd0);

        // bus_clk held high: one capture per rise only
        capture(8'h7E, 1'b1, 300);
        capture(8'h81, 1'b1, 300);
        drain();

        for (int i = 0; i < NRAND; i++) begin
            capture(8'($urandom), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3));
            repeat ($urandom_range(0, FRAME / 3)) @(negedge clk);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule

// File: doc/out_uart_tx.md
# out_uart_tx

- Mirrors the output register over `usb_tx`: every bus cycle with `OI` asserted, the bus byte is captured, queued in a small FIFO and sent as an 8N1 UART frame.
- Gives a host the same values the seven-segment display shows.
- Instantiated in `top` next to `sev_seg_out`, on the 100 MHz board clock; watches `bus_clk` as a sampled level.

## Interface
- `CLK_FREQ`, 100000000, board clock frequency in Hz
- `BAUD`, 1000000, serial bit rate; `CLKS_PER_BIT = CLK_FREQ/BAUD` must be ≥ 2 and is integer-truncated
- `FIFO_DEPTH`, 4, capture queue depth; power of two, ≥ 2

- `clk` input 1: 100 MHz clock, single clock domain
- `rst_n` input 1: asynchronous, active-low reset
- `bus` input 8: main bus value
- `OI` input 1: output-register load control from control logic
- `bus_clk` input 1: CPU bus clock level, derived from `clk`; no synchroniser required
- `tx` output 1: UART line, idle high; drives `usb_tx`
- `busy` output 1: high while a frame is on the line or the FIFO is non-empty
- `overflow` output 1: sticky; a capture was dropped because the FIFO was full

## Operation
- Capture:
  - Register `bus_clk` as `bus_clk_q`; a rising edge is `bus_clk & ~bus_clk_q`.
  - In that cycle, if `OI` = 1, push `bus` into the FIFO. `OI`/`bus` are sampled in the detect cycle only.
- FIFO:
  - Push when full is dropped and sets `overflow`, unless a pop occurs in the same cycle. In that case the push is accepted.
  - Pop and push on an empty FIFO: the push is stored; nothing is popped.
- Serializer states:
  - IDLE: `tx` = 1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: `tx` = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx` = shift[0] for CLKS_PER_BIT cycles per bit, LSB first. Go to STOP after index 7.
  - STOP: `tx` = 1 for CLKS_PER_BIT cycles. On the last cycle, if the FIFO is non-empty, pop and go directly to START; otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, cleared on every state entry, and wraps to 0 at each bit boundary.
- `busy` = (state ≠ IDLE) | FIFO non-empty.
- Reset, asserted at any time including mid-frame:
  - `tx` = 1, `busy` = 0, `overflow` = 0.
  - FIFO emptied, state IDLE, counters 0.
  - A partial frame is abandoned.

## Timing
- Edge detected in cycle N → FIFO count increments at N+1.
- If IDLE: pop at N+1, `tx` falls at N+2.
- Frame length: 10·CLKS_PER_BIT cycles (1000 at defaults).
- Back-to-back frames: no idle gap; the next start bit follows the stop bit's last cycle.
- All outputs registered; `tx` glitch-free.

## Configuration
- `OUT_UART_TX_ASCII_EN` defined:
  - Each FIFO entry is sent as 4 frames: upper hex digit, lower hex digit, 0x0D, 0x0A.
  - Hex digits are ASCII `0`–`9`, `A`–`F` (uppercase).
  - The entry is popped at the first character. A 2-bit character index advances in STOP.
  - The next entry is popped only after 0x0A completes.
- Undefined: the raw byte is sent as one frame.
- Capture, FIFO and overflow behaviour are identical in both cases.

## Structure
- Package `out_uart_tx_pkg`:
  - serializer state enum (IDLE, START, DATA, STOP)
  - `clks_per_bit` function
  - ASCII constants (CR, LF, hex-digit table)
- Sub-module `uart_tx_frame`:
  - shift register, baud counter, state machine
  - ports: `clk`, `rst_n`, `data[7:0]`, `valid`, `ready`, `tx`
  - `ready` is high in IDLE and in the last STOP cycle
- Parent holds: edge detect, FIFO, overflow flag and the optional ASCII sequencer.

## Test plan
- Raw mode, defaults, `bus` = 0x5A with `OI` = 1 for one `bus_clk` rise → `tx` low 2 cycles after the edge; bits 0,1,0,1,1,0,1,0 at 100-cycle spacing; stop high; `busy` falls after 1000 cycles.
- `bus_clk` rises with `OI` = 0 and `bus` = 0xFF → no frame; `tx` stays 1; `busy` stays 0.
- Five captures (0x01..0x05) within one frame time, `FIFO_DEPTH` = 4 → the in-flight byte plus 4 queued bytes are sent in order, frames contiguous; `overflow` stays 0. A sixth capture before the first frame ends sets `overflow`, and that byte is never sent.
- Assert `rst_n` = 0 in the middle of DATA of 0xC3 → `tx` = 1 immediately, `busy` = 0. After release the FIFO is empty and no residual frame appears.
- With `OUT_UART_TX_ASCII_EN`, capture 0x7E → frames 0x37, 0x45, 0x0D, 0x0A back-to-back, total 4000 cycles.
- `bus_clk` held high for many `clk` cycles with `OI` = 1 → exactly one capture per rising edge.
